// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared types and constants for the UART command bridge.
package uart_bridge_pkg;

    // Frame parser states.
    typedef enum logic [1:0] {
        StIdle,
        StLen,
        StCmd,
        StPay
    } cmd_state_t;

    // Upper nibble that marks a header byte unless overridden per instance.
    localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;

    typedef logic [3:0] cmd_op_t;

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: inter-byte idle counter used by uart_cmd_ctrl.
module uart_timeout_cnt #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Raised on the last counting cycle; the owner decides whether a byte beats it.
    assign expired = count_en && (cnt_q == CntMax);

    // Clear wins over counting; wrap after expiry so a stale maximum never lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes into a command header plus payload stream.
// Optional inter-byte timeout is built in when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [3:0]  SYNC_NIBBLE    = SYNC_NIBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [3:0]  cmd_op,
    output logic [7:0]  cmd_len,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_last,
    input  logic        pay_ready,
    output logic        err_sync,
    output logic        err_timeout,
    output logic        pay_abort,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    cmd_state_t  state_q, state_d;
    cmd_op_t     op_q;
    logic [7:0]  len_q;
    logic [7:0]  rem_q;
    logic [15:0] frame_cnt_q;
    logic        err_sync_q;

    logic rx_fire;
    logic pay_fire;
    logic hdr_ok;
    logic frame_done;
    logic tmo_fire;

    assign rx_fire  = rx_valid && rx_ready;
    assign pay_fire = pay_valid && pay_ready;
    assign hdr_ok   = (rx_data[7:4] == SYNC_NIBBLE);

    // A frame completes on the header handshake of an empty frame or on the last payload beat.
    assign frame_done = ((state_q == StCmd) && cmd_ready && (len_q == 8'd0)) ||
                        ((state_q == StPay) && pay_fire && (rem_q == 8'd1));

`ifdef UART_CMD_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_count;
    logic tmo_expired;

    // Restart on every byte and when the header is handed off (entry to PAY).
    assign tmo_clear = rx_fire || ((state_q == StCmd) && cmd_ready);
    // A downstream stall (byte waiting, pay_ready low) must not count.
    assign tmo_count = (state_q == StLen) || ((state_q == StPay) && !rx_valid);

    uart_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmo_clear),
        .count_en (tmo_count),
        .expired  (tmo_expired)
    );

    assign tmo_fire    = tmo_expired && !rx_fire;
    assign err_timeout = tmo_fire;
    assign pay_abort   = tmo_fire && (state_q == StPay);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
    assign pay_abort   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (rx_fire && hdr_ok) state_d = StLen;
            StLen: begin
                if (rx_fire) state_d = StCmd;
                else if (tmo_fire) state_d = StIdle;
            end
            StCmd: if (cmd_ready) state_d = (len_q == 8'd0) ? StIdle : StPay;
            StPay: begin
                if (pay_fire && (rem_q == 8'd1)) state_d = StIdle;
                else if (tmo_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; payload is a pure pass-through while in PAY.
    always_comb begin
        rx_ready  = 1'b1;
        cmd_valid = 1'b0;
        pay_valid = 1'b0;
        pay_last  = 1'b0;
        busy      = (state_q != StIdle);
        case (state_q)
            StCmd: begin
                rx_ready  = 1'b0;
                cmd_valid = 1'b1;
            end
            StPay: begin
                rx_ready  = pay_ready;
                pay_valid = rx_valid;
                pay_last  = (rem_q == 8'd1);
            end
            default: ;
        endcase
    end

    // Header fields, remaining-byte count, frame counter and sync error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            frame_cnt_q <= '0;
            err_sync_q  <= 1'b0;
        end else begin
            err_sync_q <= (state_q == StIdle) && rx_fire && !hdr_ok;
            if ((state_q == StIdle) && rx_fire && hdr_ok) begin
                op_q <= rx_data[3:0];
            end
            if ((state_q == StLen) && rx_fire) begin
                len_q <= rx_data;
                rem_q <= rx_data;
            end else if ((state_q == StPay) && pay_fire) begin
                rem_q <= rem_q - 8'd1;
            end
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign cmd_op    = op_q;
    assign cmd_len   = len_q;
    assign pay_data  = rx_data;
    assign err_sync  = err_sync_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized checks of the UART command framer.
module tb_uart_cmd_ctrl;

    localparam int unsigned TMO  = 50;
    localparam logic [3:0]  SYNC = 4'hA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_last;
    logic        pay_ready = 1'b0;
    logic        err_sync;
    logic        err_timeout;
    logic        pay_abort;
    logic        busy;
    logic [15:0] frame_cnt;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_NIBBLE    (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_last    (pay_last),
        .pay_ready   (pay_ready),
        .err_sync    (err_sync),
        .err_timeout (err_timeout),
        .pay_abort   (pay_abort),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_frames = 0;
    bit rand_ready = 1'b0;

    // Observations gathered on the falling edge.
    int          cyc = 0;
    logic [11:0] obs_cmd[$];
    logic [8:0]  obs_pay[$];
    int n_sync = 0, n_tmo = 0, n_abort = 0, n_cmd_cyc = 0;
    int n_both = 0, n_unstable = 0, n_rdy_in_cmd = 0;
    int last_acc_cyc = 0;
    logic        prev_cv = 1'b0;
    logic [11:0] prev_cmd = '0;

    // Reference model outputs.
    logic [11:0] exp_cmd[$];
    logic [8:0]  exp_pay[$];
    int exp_sync_n, exp_frame_n;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) last_acc_cyc <= cyc;
            if (cmd_valid && cmd_ready) obs_cmd.push_back({cmd_op, cmd_len});
            if (pay_valid && pay_ready) obs_pay.push_back({pay_last, pay_data});
            if (cmd_valid) n_cmd_cyc <= n_cmd_cyc + 1;
            if (err_sync) n_sync <= n_sync + 1;
            if (cmd_valid && pay_valid) n_both <= n_both + 1;
            if (cmd_valid && rx_ready) n_rdy_in_cmd <= n_rdy_in_cmd + 1;
            if (prev_cv && cmd_valid && ({cmd_op, cmd_len} !== prev_cmd))
                n_unstable <= n_unstable + 1;
        end
        if (err_timeout) n_tmo <= n_tmo + 1;
        if (pay_abort) n_abort <= n_abort + 1;
        prev_cv  <= cmd_valid;
        prev_cmd <= {cmd_op, cmd_len};
    end

    // Background randomizer for the downstream ready signals.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                cmd_ready = 1'($urandom_range(0, 1));
                pay_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, got no finish want finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte: byte %h stalled, rx_ready got %b want 1", b, rx_ready);
        end
        rx_valid = 1'b0;
    endtask

    // Frame parser written straight from the byte-stream format.
    task automatic model(input logic [7:0] bq[$]);
        int i;
        int n;
        logic [3:0] op;
        exp_cmd.delete();
        exp_pay.delete();
        exp_sync_n  = 0;
        exp_frame_n = 0;
        i = 0;
        while (i < bq.size()) begin
            if (bq[i][7:4] != SYNC) begin
                exp_sync_n++;
                i++;
            end else begin
                op = bq[i][3:0];
                n  = int'(bq[i+1]);
                exp_cmd.push_back({op, bq[i+1]});
                for (int k = 0; k < n; k++) exp_pay.push_back({(k == n - 1), bq[i+2+k]});
                exp_frame_n++;
                i += 2 + n;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_data = 8'h37;
        rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (rx_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_cmp++;
        if (cmd_valid !== 1'b0 || pay_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valids: got %b%b want 00", cmd_valid, pay_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (frame_cnt !== 16'd0 || cmd_op !== 4'd0 || cmd_len !== 8'd0) begin n_fail++;
            $display("FAIL reset_regs: got %h/%h/%h want 0/0/0", frame_cnt, cmd_op, cmd_len); end
        n_cmp++;
        if ({err_sync, err_timeout, pay_abort} !== 3'b000) begin n_fail++;
            $display("FAIL reset_pulses: got %b want 000", {err_sync, err_timeout, pay_abort});
        end
        n_cmp++;
        rx_valid = 1'b0;
        rst_n = 1'b1;
        exp_frames = 0;
        idle(1);
    endtask

    task automatic test_basic();
        int bc, bp;
        cmd_ready = 1'b1;
        pay_ready = 1'b1;
        bc = obs_cmd.size();
        bp = obs_pay.size();
        send_byte(8'hA3, 0);
        send_byte(8'h02, 0);
        if (cmd_valid !== 1'b1) begin n_fail++;
            $display("FAIL basic_cmd_valid_latency: got %b want 1", cmd_valid); end
        n_cmp++;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        idle(2);
        exp_frames++;
        if (obs_cmd.size() != bc + 1 || obs_cmd[bc] !== {4'h3, 8'h02}) begin n_fail++;
            $display("FAIL basic_cmd: got n=%0d %h want n=1 302", obs_cmd.size() - bc,
                     obs_cmd[bc]); end
        n_cmp++;
        if (obs_pay.size() != bp + 2 || obs_pay[bp] !== 9'h011 || obs_pay[bp+1] !== 9'h122)
        begin n_fail++;
            $display("FAIL basic_payload: got n=%0d %h %h want n=2 011 122",
                     obs_pay.size() - bp, obs_pay[bp], obs_pay[bp+1]); end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin n_fail++;
            $display("FAIL basic_done: got cnt=%0d busy=%b want cnt=%0d busy=0",
                     frame_cnt, busy, exp_frames); end
        n_cmp++;
    endtask

    task automatic test_zero_len();
        int bc, bp, cc;
        bc = obs_cmd.size();
        bp = obs_pay.size();
        cc = n_cmd_cyc;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        if (cmd_valid !== 1'b1 || cmd_op !== 4'h5 || cmd_len !== 8'h00) begin n_fail++;
            $display("FAIL zero_hdr: got v=%b op=%h len=%h want 1 5 00", cmd_valid, cmd_op,
                     cmd_len); end
        n_cmp++;
        idle(3);
        exp_frames++;
        if (n_cmd_cyc - cc != 1 || obs_cmd.size() != bc + 1) begin n_fail++;
            $display("FAIL zero_single_cmd: got cyc=%0d hs=%0d want 1 1", n_cmd_cyc - cc,
                     obs_cmd.size() - bc); end
        n_cmp++;
        if (obs_pay.size() != bp) begin n_fail++;
            $display("FAIL zero_no_payload: got %0d beats want 0", obs_pay.size() - bp); end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin n_fail++;
            $display("FAIL zero_done: got cnt=%0d busy=%b want cnt=%0d busy=0",
                     frame_cnt, busy, exp_frames); end
        n_cmp++;
    endtask

    task automatic test_sync_err();
        int s0;
        s0 = n_sync;
        send_byte(8'h37, 0);
        if (err_sync !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL sync_pulse: got err=%b busy=%b want 1 0", err_sync, busy); end
        n_cmp++;
        idle(1);
        if (err_sync !== 1'b0) begin n_fail++;
            $display("FAIL sync_one_cycle: got %b want 0", err_sync); end
        n_cmp++;
        send_byte(8'hA1, 0);
        send_byte(8'h01, 0);
        send_byte(8'hFF, 0);
        idle(2);
        exp_frames++;
        if (n_sync - s0 != 1) begin n_fail++;
            $display("FAIL sync_count: got %0d want 1", n_sync - s0); end
        n_cmp++;
        if (obs_cmd[$] !== {4'h1, 8'h01} || obs_pay[$] !== 9'h1FF) begin n_fail++;
            $display("FAIL sync_next_frame: got %h %h want 101 1ff", obs_cmd[$], obs_pay[$]); end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames)) begin n_fail++;
            $display("FAIL sync_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        n_cmp++;
    endtask

    task automatic test_backpressure();
        int bad, t0, u0, bp;
        bad = 0;
        t0 = n_tmo;
        u0 = n_unstable;
        bp = obs_pay.size();
        cmd_ready = 1'b0;
        pay_ready = 1'b1;
        send_byte(8'hA4, 0);
        send_byte(8'h03, 0);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rx_ready !== 1'b0 || cmd_valid !== 1'b1 || cmd_op !== 4'h4 || cmd_len !== 8'h03)
                bad++;
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        pay_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rx_ready !== 1'b0) bad++;
        end
        @(posedge clk);
        #1;
        pay_ready = 1'b1;
        send_byte(8'h5A, 0);
        send_byte(8'h6B, 0);
        send_byte(8'h7C, 0);
        idle(2);
        exp_frames++;
        if (bad != 0) begin n_fail++;
            $display("FAIL bp_stall: got %0d bad stall cycles want 0", bad); end
        n_cmp++;
        if (obs_pay.size() != bp + 3 || obs_pay[bp] !== 9'h05A || obs_pay[bp+1] !== 9'h06B ||
            obs_pay[bp+2] !== 9'h17C) begin n_fail++;
            $display("FAIL bp_payload: got n=%0d %h %h %h want n=3 05a 06b 17c",
                     obs_pay.size() - bp, obs_pay[bp], obs_pay[bp+1], obs_pay[bp+2]); end
        n_cmp++;
        if (n_tmo != t0 || n_unstable != u0) begin n_fail++;
            $display("FAIL bp_clean: got tmo=%0d unstable=%0d want 0 0", n_tmo - t0,
                     n_unstable - u0); end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames)) begin n_fail++;
            $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        n_cmp++;
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int acc, t0, a0;
        cmd_ready = 1'b1;
        pay_ready = 1'b1;
        a0 = n_abort;
        send_byte(8'hA2, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        acc = last_acc_cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) break;
        end
        if (err_timeout !== 1'b1 || pay_abort !== 1'b1 || cyc - acc != int'(TMO)) begin n_fail++;
            $display("FAIL tmo_pay: got tmo=%b abort=%b after %0d want 1 1 after %0d",
                     err_timeout, pay_abort, cyc - acc, TMO); end
        n_cmp++;
        @(posedge clk);
        #1;
        if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames) || n_abort - a0 != 1) begin n_fail++;
            $display("FAIL tmo_pay_after: got busy=%b cnt=%0d aborts=%0d want 0 %0d 1",
                     busy, frame_cnt, n_abort - a0, exp_frames); end
        n_cmp++;
        send_byte(8'hA7, 0);
        acc = last_acc_cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) break;
        end
        if (err_timeout !== 1'b1 || pay_abort !== 1'b0 || cyc - acc != int'(TMO)) begin n_fail++;
            $display("FAIL tmo_len: got tmo=%b abort=%b after %0d want 1 0 after %0d",
                     err_timeout, pay_abort, cyc - acc, TMO); end
        n_cmp++;
        @(posedge clk);
        #1;
        t0 = n_tmo;
        send_byte(8'hA2, 0);
        send_byte(8'h02, 0);
        rx_data   = 8'h44;
        rx_valid  = 1'b1;
        pay_ready = 1'b0;
        idle(70);
        if (n_tmo != t0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL tmo_hold: got tmo=%0d busy=%b want 0 1", n_tmo - t0, busy); end
        n_cmp++;
        pay_ready = 1'b1;
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        idle(2);
        exp_frames++;
        if (frame_cnt !== 16'(exp_frames) || obs_pay[$] !== 9'h155) begin n_fail++;
            $display("FAIL tmo_recover: got cnt=%0d last=%h want %0d 155", frame_cnt,
                     obs_pay[$], exp_frames); end
        n_cmp++;
    endtask
`else
    task automatic test_timeout();
        int t0, a0;
        cmd_ready = 1'b1;
        pay_ready = 1'b1;
        t0 = n_tmo;
        a0 = n_abort;
        send_byte(8'hA2, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        idle(200);
        if (busy !== 1'b1 || n_tmo != t0 || n_abort != a0) begin n_fail++;
            $display("FAIL notmo_wait: got busy=%b tmo=%0d abort=%0d want 1 0 0", busy,
                     n_tmo - t0, n_abort - a0); end
        n_cmp++;
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        idle(2);
        exp_frames++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0 || obs_pay[$] !== 9'h103) begin
            n_fail++;
            $display("FAIL notmo_finish: got cnt=%0d busy=%b last=%h want %0d 0 103",
                     frame_cnt, busy, obs_pay[$], exp_frames); end
        n_cmp++;
    endtask
`endif

    task automatic test_reset_mid();
        int a0, bp;
        cmd_ready = 1'b1;
        pay_ready = 1'b1;
        send_byte(8'hA6, 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        a0 = n_abort;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        if (busy !== 1'b0 || rx_ready !== 1'b1 || cmd_valid !== 1'b0 || pay_valid !== 1'b0)
        begin n_fail++;
            $display("FAIL rstmid_ctrl: got busy=%b rdy=%b cv=%b pv=%b want 0 1 0 0", busy,
                     rx_ready, cmd_valid, pay_valid); end
        n_cmp++;
        if (frame_cnt !== 16'd0 || cmd_op !== 4'd0 || cmd_len !== 8'd0 || pay_abort !== 1'b0)
        begin n_fail++;
            $display("FAIL rstmid_regs: got cnt=%0d op=%h len=%h abort=%b want 0 0 00 0",
                     frame_cnt, cmd_op, cmd_len, pay_abort); end
        n_cmp++;
        repeat (3) @(posedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (n_abort != a0) begin n_fail++;
            $display("FAIL rstmid_no_abort: got %0d aborts want 0", n_abort - a0); end
        n_cmp++;
        bp = obs_pay.size();
        send_byte(8'hA3, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        idle(2);
        exp_frames++;
        if (obs_pay.size() != bp + 2 || obs_pay[bp] !== 9'h011 || obs_pay[bp+1] !== 9'h122 ||
            frame_cnt !== 16'(exp_frames)) begin n_fail++;
            $display("FAIL rstmid_rerun: got n=%0d cnt=%0d want n=2 cnt=%0d",
                     obs_pay.size() - bp, frame_cnt, exp_frames); end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [7:0] bq[$];
        logic [7:0] b;
        int len, bc, bp, s0;
        logic [11:0] gc;
        logic [8:0]  gp;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = 8'($urandom);
                if (b[7:4] == SYNC) b[7:4] = 4'h5;
                bq.push_back(b);
            end
            len = $urandom_range(0, 6);
            bq.push_back({SYNC, 4'($urandom)});
            bq.push_back(8'(len));
            for (int k = 0; k < len; k++) bq.push_back(8'($urandom));
        end
        model(bq);
        bc = obs_cmd.size();
        bp = obs_pay.size();
        s0 = n_sync;
        rand_ready = 1'b1;
        foreach (bq[i]) send_byte(bq[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
        rand_ready = 1'b0;
        cmd_ready  = 1'b1;
        pay_ready  = 1'b1;
        idle(4);
        exp_frames += exp_frame_n;
        if (obs_cmd.size() - bc != exp_cmd.size() || obs_pay.size() - bp != exp_pay.size())
        begin n_fail++;
            $display("FAIL rand_sizes: got cmd=%0d pay=%0d want cmd=%0d pay=%0d",
                     obs_cmd.size() - bc, obs_pay.size() - bp, exp_cmd.size(), exp_pay.size());
        end
        n_cmp++;
        foreach (exp_cmd[k]) begin
            gc = (bc + k < obs_cmd.size()) ? obs_cmd[bc+k] : 12'hxxx;
            if (gc !== exp_cmd[k]) begin n_fail++;
                $display("FAIL rand_cmd[%0d]: got %h want %h", k, gc, exp_cmd[k]); end
            n_cmp++;
        end
        foreach (exp_pay[k]) begin
            gp = (bp + k < obs_pay.size()) ? obs_pay[bp+k] : 9'hxxx;
            if (gp !== exp_pay[k]) begin n_fail++;
                $display("FAIL rand_pay[%0d]: got %h want %h", k, gp, exp_pay[k]); end
            n_cmp++;
        end
        if (n_sync - s0 != exp_sync_n) begin n_fail++;
            $display("FAIL rand_sync: got %0d want %0d", n_sync - s0, exp_sync_n); end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin n_fail++;
            $display("FAIL rand_cnt: got cnt=%0d busy=%b want %0d 0", frame_cnt, busy,
                     exp_frames); end
        n_cmp++;
        if (n_both != 0 || n_unstable != 0 || n_rdy_in_cmd != 0) begin n_fail++;
            $display("FAIL rand_protocol: got both=%0d unstable=%0d rdy_in_cmd=%0d want 0 0 0",
                     n_both, n_unstable, n_rdy_in_cmd); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_sync_err();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the inter-byte idle limit in clk cycles.
REQ-002 SHALL have parameter SYNC_NIBBLE, default 4'hA, meaning the required upper nibble of a header byte.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8, byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, rx_data valid; held until accepted.
REQ-007 SHALL have port rx_ready, output, 1, byte accept (back-pressure to the UART receiver).
REQ-008 SHALL have port cmd_op, output, 4, opcode of the current frame.
REQ-009 SHALL have port cmd_len, output, 8, payload byte count of the current frame.
REQ-010 SHALL have port cmd_valid, output, 1, command header present.
REQ-011 SHALL have port cmd_ready, input, 1, JTAG engine accepts the header.
REQ-012 SHALL have ports pay_data (output, 8), pay_valid (output, 1), pay_last (output, 1) and pay_ready (input, 1), forming the payload stream to the JTAG engine.
REQ-013 SHALL have ports err_sync, err_timeout and pay_abort, each output, 1, one-cycle pulses; busy, output, 1, high when not in IDLE; frame_cnt, output, 16, count of completed frames.

Function
REQ-014 SHALL transfer data on any valid/ready pair only in a cycle where both are high.
REQ-015 Frame format SHALL be: header byte {SYNC_NIBBLE, op[3:0]}, then length byte N, then N payload bytes; N=0 is legal.
REQ-016 SHALL have states IDLE, LEN, CMD and PAY, with IDLE as the reset state.
REQ-017 IDLE: rx_ready=1; on an accepted byte whose upper nibble equals SYNC_NIBBLE, SHALL latch op and go to LEN; otherwise SHALL pulse err_sync the next cycle, drop the byte and stay in IDLE.
REQ-018 LEN: rx_ready=1; on an accepted byte SHALL latch cmd_len, load remaining=N and go to CMD.
REQ-019 CMD: rx_ready=0 and cmd_valid=1; cmd_op and cmd_len SHALL be stable; on cmd_ready, SHALL go to IDLE if N=0 (incrementing frame_cnt), else go to PAY.
REQ-020 cmd_valid SHALL assert on the first cycle after the length byte is accepted.
REQ-021 PAY: the payload path SHALL be combinational pass-through, with pay_data=rx_data, pay_valid=rx_valid and rx_ready=pay_ready.
REQ-022 PAY: pay_last SHALL equal (remaining==1); each transfer SHALL decrement remaining.
REQ-023 PAY: the transfer with pay_last SHALL return the FSM to IDLE and increment frame_cnt.
REQ-024 In every state other than PAY, pay_valid SHALL be 0; cmd_valid SHALL be 0 outside CMD.
REQ-025 frame_cnt SHALL wrap from 16'hFFFF to 0.
REQ-026 Timeout counter SHALL clear on every accepted byte and on entry to LEN/PAY.
REQ-027 Timeout counter SHALL count only in LEN, or in PAY while rx_valid=0; it SHALL hold while rx_valid=1 and pay_ready=0, since the stall is downstream.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1 while still counting, the FSM SHALL pulse err_timeout, go to IDLE and not increment frame_cnt.
REQ-029 A timeout in PAY SHALL also pulse pay_abort in the same cycle.
REQ-030 If a byte is accepted in the same cycle the timeout would fire, the byte SHALL win and no timeout SHALL occur.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously enter IDLE and clear remaining, the timeout counter, frame_cnt, cmd_op, cmd_len and all pulses.
REQ-032 During reset, rx_ready SHALL read 1 and cmd_valid/pay_valid SHALL read 0.
REQ-033 Reset mid-frame SHALL discard the partial frame without pulsing pay_abort.

Configuration
REQ-034 Macro UART_CMD_TIMEOUT_EN defined: the timeout counter and the err_timeout/pay_abort behaviour SHALL be present.
REQ-035 Macro UART_CMD_TIMEOUT_EN undefined: the counter SHALL be omitted, err_timeout and pay_abort SHALL be tied 0, and frames SHALL wait indefinitely.

Structure
REQ-036 Package uart_bridge_pkg SHALL hold the state enum (cmd_state_t), the default SYNC_NIBBLE constant and the opcode typedef (cmd_op_t, 4 bits).
REQ-037 The timeout counter SHALL be the single sub-module uart_timeout_cnt (inputs clear and count_en; output expired), instantiated only under UART_CMD_TIMEOUT_EN.

Verification
REQ-038 Bench SHALL drive bytes A3,02,11,22 with cmd_ready=1 and pay_ready=1 and check cmd_op=3, cmd_len=2, payload 11,22 with pay_last on 22, and frame_cnt=1.
REQ-039 Bench SHALL drive bytes A5,00 and check a single cmd_valid with cmd_len=0, no pay_valid, return to IDLE, and frame_cnt incremented.
REQ-040 Bench SHALL drive byte 37 then A1,01,FF and check an err_sync pulse for 37 followed by a normal frame.
REQ-041 Bench SHALL hold cmd_ready=0 for 20 cycles and then pay_ready=0 for 10 cycles, and check rx_ready=0 throughout, no byte loss and no timeout.
REQ-042 Bench SHALL set TIMEOUT_CYCLES=50, send A2,03,01 then stop, and check err_timeout plus pay_abort 50 cycles after the last byte, IDLE, and frame_cnt unchanged.
REQ-043 Bench SHALL assert rst_n low during PAY and check immediate IDLE, outputs at reset values and no pay_abort, then re-run the first scenario successfully.
